// File: rtl/can_host_bus_bridge.sv
// can_host_bus_bridge: multiplexed host bus to CAN core request bridge with local IRQ_STAT/IRQ_MASK; optional response timeout under CAN_HB_TIMEOUT_EN
module can_host_bus_bridge #(
    parameter int DATA_W      = 8,
    parameter int NUM_CH      = 2,
    parameter int TIMEOUT_CYC = 255,
    localparam int CH_W       = NUM_CH > 1 ? $clog2(NUM_CH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              bus_ale,
    input  logic              bus_cs,
    input  logic              bus_wr,
    input  logic              bus_rd,
    input  logic [DATA_W-1:0] bus_ad_i,
    output logic [DATA_W-1:0] bus_ad_o,
    output logic              bus_ad_oe,
    output logic              bus_rdy,
    output logic              bus_int,
    output logic              req_valid,
    input  logic              req_ready,
    output logic              req_write,
    output logic [CH_W-1:0]   req_ch,
    output logic [DATA_W-1:0] req_addr,
    output logic [DATA_W-1:0] req_wdata,
    input  logic              rsp_valid,
    input  logic [DATA_W-1:0] rsp_rdata,
    input  logic [NUM_CH-1:0] core_irq
);
    localparam int CB = $clog2(NUM_CH);
    typedef enum logic [2:0] {IDLE, ADDR, REQ, WAIT_RSP, HOLD} state_t;
    state_t state, state_n, done;
    logic [1:0] ale_q, cs_q, wr_q, rd_q;
    logic ale_d, cs_d, wr_d, rd_d;
    logic ale_fall, cs_rise, wr_fall, rd_fall, wr_rise, rd_rise;
    logic acc, abort, abort_n, is_rd, is_local, is_stat, stat_rd, stat_wr, tmo_hit, tmo_b;
    logic [DATA_W-1:0] addr;
    logic [NUM_CH-1:0] pending, mask, irq_d, clr;
    assign ale_fall = ale_d & ~ale_q[1];
    assign cs_rise  = ~cs_d & cs_q[1];
    assign wr_fall  = wr_d & ~wr_q[1];
    assign rd_fall  = rd_d & ~rd_q[1];
    assign wr_rise  = ~wr_d & wr_q[1];
    assign rd_rise  = ~rd_d & rd_q[1];
    assign acc      = state == ADDR && !cs_q[1] && (wr_fall ^ rd_fall);
    assign is_local = &addr[DATA_W-1:1];
    assign is_stat  = &addr;
    assign stat_rd  = acc && is_stat && rd_fall;
    assign stat_wr  = acc && is_stat && wr_fall;
    assign clr      = stat_rd ? pending : stat_wr ? bus_ad_i[NUM_CH-1:0] : '0;
    assign abort_n  = abort | cs_rise;
    assign done     = abort_n ? IDLE : HOLD;
`ifdef CAN_HB_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    logic [CNT_W-1:0] cnt;
    logic tmo;
    assign tmo_hit = ((state == REQ && !req_ready) || (state == WAIT_RSP && !rsp_valid)) && cnt == CNT_W'(TIMEOUT_CYC - 1);
    assign tmo_b   = tmo;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt <= '0;
            tmo <= 1'b0;
        end else begin
            cnt <= state_n != state ? '0 : cnt + 1'b1;
            tmo <= tmo_hit | (tmo & ~(stat_rd | (stat_wr & bus_ad_i[DATA_W-1])));
        end
    end
`else
    assign tmo_hit = 1'b0;
    assign tmo_b   = 1'b0;
`endif
    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_n;
    end
    always_comb begin
        state_n = state;
        case (state)
            IDLE:     if (ale_fall && !cs_q[1]) state_n = ADDR;
            ADDR:     if (cs_rise) state_n = IDLE;
                      else if (acc) state_n = is_local ? HOLD : REQ;
            REQ:      if (req_ready) state_n = req_write ? done : WAIT_RSP;
                      else if (tmo_hit) state_n = done;
            WAIT_RSP: if (rsp_valid || tmo_hit) state_n = done;
            HOLD:     if (wr_rise || rd_rise || cs_rise) state_n = IDLE;
            default:  state_n = IDLE;
        endcase
    end
    always_comb begin
        bus_rdy   = state == HOLD;
        bus_ad_oe = state == HOLD && is_rd && !rd_q[1];
        req_valid = state == REQ;
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ale_q     <= '0;
            cs_q      <= '1;
            wr_q      <= '1;
            rd_q      <= '1;
            ale_d     <= 1'b0;
            cs_d      <= 1'b1;
            wr_d      <= 1'b1;
            rd_d      <= 1'b1;
            addr      <= '0;
            is_rd     <= 1'b0;
            abort     <= 1'b0;
            req_write <= 1'b0;
            req_ch    <= '0;
            req_addr  <= '0;
            req_wdata <= '0;
            bus_ad_o  <= '0;
            pending   <= '0;
            mask      <= '0;
            irq_d     <= '0;
            bus_int   <= 1'b1;
        end else begin
            ale_q <= {ale_q[0], bus_ale};
            cs_q  <= {cs_q[0], bus_cs};
            wr_q  <= {wr_q[0], bus_wr};
            rd_q  <= {rd_q[0], bus_rd};
            ale_d <= ale_q[1];
            cs_d  <= cs_q[1];
            wr_d  <= wr_q[1];
            rd_d  <= rd_q[1];
            if (ale_fall && !cs_q[1] && (state == IDLE || state == ADDR)) addr <= bus_ad_i;
            abort <= (state == REQ || state == WAIT_RSP) && abort_n;
            if (acc) is_rd <= rd_fall;
            if (acc && !is_local) begin
                req_write <= wr_fall;
                req_ch    <= CH_W'(addr >> (DATA_W - CB));
                req_addr  <= addr & ({DATA_W{1'b1}} >> CB);
                req_wdata <= bus_ad_i;
            end
            if (acc && is_local && rd_fall) bus_ad_o <= is_stat ? {tmo_b, (DATA_W-1)'(pending)} : DATA_W'(mask);
            else if (state == WAIT_RSP && rsp_valid) bus_ad_o <= rsp_rdata;
            else if (tmo_hit && !req_write) bus_ad_o <= '1;
            if (acc && is_local && !is_stat && wr_fall) mask <= bus_ad_i[NUM_CH-1:0];
            pending <= (pending & ~clr) | (core_irq & ~irq_d);
            irq_d   <= core_irq;
            bus_int <= ~(|(pending & mask) | tmo_b);
        end
    end
endmodule

// File: doc/can_host_bus_bridge.md
CAN_HOST_BUS_BRIDGE -- requirements
Module: can_host_bus_bridge

Interface
REQ-001 Parameter DATA_W, 8, width of multiplexed address/data bus and register data.
REQ-002 Parameter NUM_CH, 2, number of CAN core channels served; power of two, 1..DATA_W-1.
REQ-003 Parameter TIMEOUT_CYC, 255, core response timeout in clk cycles (used only under CAN_HB_TIMEOUT_EN).
REQ-004 Port clk  input  1  single clock; all logic on rising edge.
REQ-005 Port rst_n  input  1  reset, synchronous, active-low.
REQ-006 Port bus_ale  input  1  address latch enable, active-high; address captured on its falling edge.
REQ-007 Port bus_cs  input  1  chip select, active-low.
REQ-008 Port bus_wr  input  1  write strobe, active-low.
REQ-009 Port bus_rd  input  1  read strobe, active-low.
REQ-010 Port bus_ad_i  input  DATA_W  multiplexed address/data from host.
REQ-011 Port bus_ad_o  output  DATA_W  read data to host.
REQ-012 Port bus_ad_oe  output  1  read data drive enable, active-high.
REQ-013 Port bus_rdy  output  1  high: current access complete (write accepted / read data valid).
REQ-014 Port bus_int  output  1  interrupt to host, active-low.
REQ-015 Port req_valid / req_ready  output / input  1 / 1  core request handshake.
REQ-016 Port req_write  output  1  1 = write, 0 = read.
REQ-017 Port req_ch  output  log2(NUM_CH) (min 1)  target channel.
REQ-018 Port req_addr / req_wdata  output  DATA_W / DATA_W  register offset / write data.
REQ-019 Port rsp_valid / rsp_rdata  input  1 / DATA_W  core read response, single-cycle pulse.
REQ-020 Port core_irq  input  NUM_CH  per-channel interrupt, level, active-high.

Function
REQ-021 bus_ale, bus_cs, bus_wr, bus_rd pass through 2-flop synchronizers; edges detected on synchronized values; bus_ad_i sampled unsynchronized at detected edge.
REQ-022 Address decode: channel = addr[DATA_W-1 -: CH_W], offset = addr with channel bits zeroed; CH_W = log2(NUM_CH).
REQ-023 Local registers, never forwarded: all-ones = IRQ_STAT, all-ones minus 1 = IRQ_MASK; they shadow those offsets of the top channel.
REQ-024 FSM states: IDLE, ADDR, REQ, WAIT_RSP, HOLD.
REQ-025 IDLE -> ADDR on ALE falling edge with cs low; address latched; new ALE falling edge in ADDR re-latches.
REQ-026 ADDR -> REQ on wr or rd falling edge with cs low; req_valid high the next cycle; rd and wr both falling same cycle: ignored, stay ADDR.
REQ-027 REQ: req_* held stable until req_valid & req_ready; write -> HOLD, read -> WAIT_RSP.
REQ-028 WAIT_RSP -> HOLD on rsp_valid; rsp_rdata captured into bus_ad_o.
REQ-029 Local register access: ADDR -> HOLD directly, one cycle, no core handshake.
REQ-030 HOLD: bus_rdy = 1; bus_ad_oe = 1 for reads while synchronized rd low; HOLD -> IDLE on strobe rising edge or cs rising.
REQ-031 cs rising in ADDR: -> IDLE; in REQ/WAIT_RSP: core handshake completes, bus_ad_oe never asserted, then -> IDLE.
REQ-032 pending[i] set on rising edge of core_irq[i]; set wins over same-cycle clear.
REQ-033 IRQ_STAT read returns pending zero-extended and clears returned bits at HOLD entry; write clears bits written 1 (W1C).
REQ-034 IRQ_MASK R/W, bits [NUM_CH-1:0]; other bits read 0.
REQ-035 bus_int = ~|(pending & mask), registered (one-cycle latency).

Reset
REQ-036 While rst_n low at clk edge: FSM IDLE, synchronizers 1 for active-low inputs and 0 for ALE, bus_ad_o 0, bus_ad_oe 0, bus_rdy 0, bus_int 1, req_valid 0, req_* 0, pending 0, mask 0.
REQ-037 Reset mid-transaction drops req_valid immediately; no core handshake completion owed.

Configuration
REQ-038 Macro CAN_HB_TIMEOUT_EN defined: counter runs in REQ/WAIT_RSP; after TIMEOUT_CYC cycles without progress, req_valid drops, read data = all ones, -> HOLD, sticky IRQ_STAT bit DATA_W-1 set (W1C, also drives bus_int, unmaskable).
REQ-039 Macro undefined: no counter, bridge waits indefinitely, IRQ_STAT bit DATA_W-1 reads 0.

Verification (DATA_W=8, NUM_CH=2)
REQ-040 ALE latch 0x85, wr low with ad=0x3C, req_ready=1 -> single req: ch=1, addr=0x05, wdata=0x3C, write=1; bus_rdy high until wr high.
REQ-041 ALE 0x12, rd low, rsp_rdata=0xA7 after 4 cycles -> bus_ad_o=0xA7, bus_ad_oe=1 until rd high, then 0.
REQ-042 mask write 0xFE<-0x03, pulse core_irq[1] -> bus_int low; read 0xFF -> 0x02; bus_int high 2 cycles later.
REQ-043 cs high while WAIT_RSP -> bus_ad_oe stays 0, FSM IDLE after rsp_valid.
REQ-044 CAN_HB_TIMEOUT_EN, TIMEOUT_CYC=16, req_ready stuck 0 -> read returns 0xFF, IRQ_STAT bit 7 set, bus_int low with mask=0.
REQ-045 rst_n low during REQ -> req_valid 0 next edge, all outputs at REQ-036 values.
